// File: rtl/down_timer_seq.sv
// Sequencer for an 8-bit loadable down counter: turns one start into N timed intervals.
// Optional watchdog on the counter handshake is enabled by defining TIMER_SEQ_WDOG_EN.
module down_timer_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] period,
    input  logic [REP_W-1:0] repeats,
    output logic             ctr_load,
    output logic             ctr_enable,
    output logic [WIDTH-1:0] ctr_data,
    input  logic             ctr_tc,
    input  logic [WIDTH-1:0] ctr_count,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [REP_W-1:0] ticks_done,
    output logic             err
);

    localparam int unsigned WD_W = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] period_q;
    logic [REP_W-1:0] repeats_q;
    logic [REP_W-1:0] ticks_q;
    logic             tick_q;
    logic             err_q;

    logic             wdog_trip_c;
    logic             stop_c;
    logic             accept_c;
    logic             tc_evt_c;
    logic             last_c;

`ifdef TIMER_SEQ_WDOG_EN
    logic [WD_W-1:0] wdog_q;
    logic            first_run_q;

    // Watchdog: interval overrun, tc without a zero count, or a load that did not land
    always_comb begin
        wdog_trip_c = 1'b0;
        if (state == RUN) begin
            wdog_trip_c = (wdog_q > ({1'b0, period_q} + WD_W'(1)))
                        || (ctr_tc && (ctr_count != '0))
                        || (first_run_q && (ctr_count != period_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q      <= '0;
            first_run_q <= 1'b0;
        end else begin
            first_run_q <= (state == LOAD);
            if (state == LOAD) begin
                wdog_q <= '0;
            end else if (state == RUN) begin
                wdog_q <= wdog_q + WD_W'(1);
            end
        end
    end
`else
    logic unused_c;

    assign wdog_trip_c = 1'b0;
    assign unused_c    = ^ctr_count;
`endif

    assign stop_c   = abort | wdog_trip_c;
    assign accept_c = (state == IDLE) && start && !abort;
    assign tc_evt_c = (state == RUN) && ctr_tc && !stop_c;
    assign last_c   = (repeats_q != '0) && ((ticks_q + REP_W'(1)) == repeats_q);

    // Next state plus the combinationally gated counter controls
    always_comb begin
        state_nxt  = state;
        ctr_load   = 1'b0;
        ctr_enable = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (stop_c) begin
                    state_nxt = IDLE;
                end else begin
                    ctr_load  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop_c) begin
                    state_nxt = IDLE;
                end else begin
                    ctr_enable = !ctr_tc;
                    if (ctr_tc) begin
                        state_nxt = last_c ? DONE : LOAD;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            period_q  <= '0;
            repeats_q <= '0;
            ticks_q   <= '0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            tick_q <= tc_evt_c;
            if (accept_c) begin
                period_q  <= period;
                repeats_q <= repeats;
                ticks_q   <= '0;
            end else if (tc_evt_c) begin
                ticks_q <= ticks_q + REP_W'(1);
            end
            if (wdog_trip_c) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ctr_data   = period_q;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign tick       = tick_q;
    assign ticks_done = ticks_q;
    assign err        = err_q;

endmodule

// File: doc/down_timer_seq.md
Name: down_timer_seq

Overview:
- Sequencer that drives the control side of an 8-bit loadable down counter (load / enable / data_in) and consumes its terminal-count flag.
- Turns a single start request into N programmed intervals (one-shot, N-shot or free-running).
- Emits one tick pulse per expiry and a done pulse when the sequence completes.
- Sits directly upstream of the down counter and is the only consumer of its tc output.

Parameters:
- WIDTH, 8, width of period / ctr_data / ctr_count; matches the down counter.
- REP_W, 8, width of repeats and ticks_done.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sequence; accepted only in IDLE
- abort  input  1  stop immediately, no done
- period  input  WIDTH  reload value, sampled on accepted start
- repeats  input  REP_W  number of intervals, sampled on accepted start; 0 = free-run
- ctr_load  output  1  to counter load
- ctr_enable  output  1  to counter enable
- ctr_data  output  WIDTH  to counter data_in
- ctr_tc  input  1  from counter tc (count == 0)
- ctr_count  input  WIDTH  from counter count; used only by the watchdog
- busy  output  1  high in LOAD/RUN/DONE
- tick  output  1  one-cycle pulse per completed interval
- done  output  1  one-cycle pulse at sequence end
- ticks_done  output  REP_W  intervals completed since the last accepted start
- err  output  1  sticky watchdog error (see Optional Feature)

Behaviour:
- Reset: state = IDLE; all outputs 0; period_q, repeats_q and ticks_done cleared. Reset mid-sequence aborts the sequence with no done.
- States are IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 and abort=0 -> latch period_q and repeats_q, clear ticks_done, go to LOAD.
  - start=1 together with abort=1 -> stay in IDLE.
- LOAD (exactly 1 cycle):
  - ctr_load=1, ctr_data=period_q, ctr_enable=0.
  - Then RUN.
- RUN:
  - ctr_load=0; ctr_enable = !ctr_tc (combinational), so the counter never decrements past 0.
  - On ctr_tc=1: ticks_done += 1 (wraps modulo 2^REP_W); tick registered high for the next cycle.
  - Next state after ctr_tc=1: DONE if repeats_q != 0 and ticks_done+1 == repeats_q; otherwise LOAD.
- DONE (1 cycle): done=1, busy=1; then IDLE.
- Interval timing:
  - Interval length is period+2 cycles: 1 LOAD + period decrement cycles + 1 tc-detect cycle.
  - period=0 gives tc on the first RUN cycle, so the interval is 2 cycles.
- Tick timing: tick coincides with the following LOAD or DONE cycle.
- ctr_data holds period_q in every state; only ctr_load qualifies it.
- abort=1 in LOAD, RUN or DONE -> IDLE on the next edge:
  - ctr_load and ctr_enable are 0 in the abort cycle itself (combinational gate).
  - No tick or done fires from that cycle.
  - ticks_done is retained.
- start while busy is ignored, including start during DONE.
- Free-run (repeats=0): intervals repeat until abort; ticks_done wraps 255 -> 0.
- period and repeats may change while busy without effect.

Optional Feature:
- Macro: TIMER_SEQ_WDOG_EN
- Defined:
  - A watchdog counter (WIDTH+1 bits) clears on LOAD and increments each RUN cycle.
  - err is set if, in RUN, any of the following holds:
    - the watchdog exceeds period_q+1;
    - ctr_tc=1 while ctr_count != 0;
    - in the cycle after LOAD, ctr_count != period_q.
  - On error: err is set sticky (cleared only by rst), and the FSM goes to IDLE as for abort.
- Undefined: no watchdog logic; err tied to 0.

Test Plan:
- Reset: rst=1 for 2 cycles -> busy=0, ctr_load=0, ctr_enable=0, tick=0, done=0, ticks_done=0, err=0.
- One-shot with a counter model attached: period=5, repeats=1, start pulse -> ctr_load=1 with ctr_data=5 for 1 cycle; ctr_enable high 5 cycles; tc seen on cycle 7 after LOAD-entry; tick then done in the same cycle; busy falls the next cycle; ticks_done=1.
- N-shot: period=3, repeats=4 -> 4 tick pulses spaced exactly 5 cycles apart; done once with the 4th tick; ticks_done=4.
- Edge values:
  - period=0, repeats=2 -> ticks 2 cycles apart, done after the 2nd.
  - period=255, repeats=1 -> tick 257 cycles after LOAD-entry.
- Abort and start interaction:
  - Free-run period=2, abort after 3 ticks -> ctr_enable=0 in the abort cycle, IDLE next cycle, no done, ticks_done=3.
  - Second start while busy -> ignored.
  - start with abort in IDLE -> stays IDLE.
- With TIMER_SEQ_WDOG_EN: counter model forced to hold tc low -> err=1 after period+2 RUN cycles, FSM returns to IDLE, err stays set until rst.
